// File: rtl/seven_seg_reader.sv
// -----------------------------------------------------------------------------
// seven_seg_reader
//
// Receives a stream of raw seven-segment bytes (one per digit, most
// significant digit first) and assembles them into a frame of NDIG decoded
// hex nibbles with per-digit decimal-point, blank and error flags.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   seg_in      segment byte, [0]=a .. [6]=g, [7]=dp, active-low
//   seg_sof     seg_in is the most significant digit of a new frame
//   seg_valid   seg_in / seg_sof valid this cycle
//   seg_ready   block accepts a byte this cycle
//   value       decoded nibbles, digit k at [4k+3:4k]
//   dp          decimal point lit per digit
//   blank_mask  digit was all segments off
//   err_mask    digit pattern was not a recognised hex glyph
//   out_valid   frame result valid, held until taken
//   out_ready   consumer takes the frame when high with out_valid
//   sync_err    one-cycle pulse when a byte is dropped for lack of sof
//   state_dbg   current FSM state (0 = IDLE, 1 = COLLECT)
//
// Handshakes: a transfer happens on any rising edge where valid && ready are
// both high; valid is held by the producer until the transfer happens and
// ready may be used combinationally by the producer. seg_ready is simply
// !out_valid, so no byte is accepted while a finished frame is pending.
// -----------------------------------------------------------------------------
module seven_seg_reader #(
  parameter int NDIG = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic              seg_sof,
  input  logic              seg_valid,
  output logic              seg_ready,
  output logic [4*NDIG-1:0] value,
  output logic [NDIG-1:0]   dp,
  output logic [NDIG-1:0]   blank_mask,
  output logic [NDIG-1:0]   err_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sync_err,
  output logic              state_dbg
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;      // index of the next byte within the frame

  // Partial-frame accumulators; only copied to the outputs on completion,
  // so the outputs never show a half-built frame.
  logic [4*NDIG-1:0] val_acc;
  logic [NDIG-1:0]   dp_acc;
  logic [NDIG-1:0]   blank_acc;
  logic [NDIG-1:0]   err_acc;

  logic              xfer;
  logic              accept;
  logic              last;
  logic [CW-1:0]     idx;
  logic [3:0]        nib;
  logic              is_blank;
  logic              is_err;
  logic [4*NDIG-1:0] nxt_val;
  logic [NDIG-1:0]   nxt_dp;
  logic [NDIG-1:0]   nxt_blank;
  logic [NDIG-1:0]   nxt_err;

  assign seg_ready = !out_valid;
  assign xfer      = seg_valid && seg_ready;
  assign state_dbg = (state == COLLECT);

  // A byte is kept if it starts a frame or continues one; a non-sof byte
  // in IDLE is dropped.
  assign accept = xfer && (seg_sof || (state == COLLECT));

  // Glyph decode on segments a..g only.
  always_comb begin
    nib      = 4'h0;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (seg_in[6:0])
      7'h40:   nib = 4'h0;
      7'h79:   nib = 4'h1;
      7'h24:   nib = 4'h2;
      7'h30:   nib = 4'h3;
      7'h19:   nib = 4'h4;
      7'h12:   nib = 4'h5;
      7'h02:   nib = 4'h6;
      7'h78:   nib = 4'h7;
      7'h00:   nib = 4'h8;
      7'h10:   nib = 4'h9;
      7'h08:   nib = 4'hA;
      7'h03:   nib = 4'hB;
      7'h46:   nib = 4'hC;
      7'h21:   nib = 4'hD;
      7'h06:   nib = 4'hE;
      7'h0E:   nib = 4'hF;
      7'h7F:   is_blank = 1'b1;
      default: is_err   = 1'b1;
    endcase
  end

  // Digit slot this byte lands in: a sof byte always restarts at the top.
  always_comb begin
    if (seg_sof || (state == IDLE)) begin
      idx = CW'(NDIG - 1);
    end else begin
      idx = CW'(NDIG - 1) - count;
    end
  end

  assign last = (idx == '0);

  // Merge the current byte into the accumulators. A sof byte starts from a
  // clean frame so nothing from a discarded partial frame survives.
  always_comb begin
    nxt_val   = seg_sof ? '0 : val_acc;
    nxt_dp    = seg_sof ? '0 : dp_acc;
    nxt_blank = seg_sof ? '0 : blank_acc;
    nxt_err   = seg_sof ? '0 : err_acc;
    nxt_val[{idx, 2'b00} +: 4] = nib;
    nxt_dp[idx]                = !seg_in[7];
    nxt_blank[idx]             = is_blank;
    nxt_err[idx]               = is_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      val_acc    <= '0;
      dp_acc     <= '0;
      blank_acc  <= '0;
      err_acc    <= '0;
      value      <= '0;
      dp         <= '0;
      blank_mask <= '0;
      err_mask   <= '0;
      out_valid  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync_err <= xfer && (state == IDLE) && !seg_sof;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (last) begin
          value      <= nxt_val;
          dp         <= nxt_dp;
          blank_mask <= nxt_blank;
          err_mask   <= nxt_err;
          out_valid  <= 1'b1;
          state      <= IDLE;
          count      <= '0;
        end else begin
          val_acc   <= nxt_val;
          dp_acc    <= nxt_dp;
          blank_acc <= nxt_blank;
          err_acc   <= nxt_err;
          state     <= COLLECT;
          count     <= seg_sof ? CW'(1) : count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_reader.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_reader
//
// Directed and randomized bench for seven_seg_reader (NDIG = 6). A byte-level
// reference model collects the bytes of each frame in a queue and decodes
// them with a glyph lookup table when the frame is complete; expected frames
// wait in exp_q until the DUT presents them.
// -----------------------------------------------------------------------------
module tb_seven_seg_reader;

  localparam int NDIG = 6;
  localparam int W    = 7 * NDIG;

  logic              clk;
  logic              rst;
  logic [7:0]        seg_in;
  logic              seg_sof;
  logic              seg_valid;
  logic              seg_ready;
  logic [4*NDIG-1:0] value;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   blank_mask;
  logic [NDIG-1:0]   err_mask;
  logic              out_valid;
  logic              out_ready;
  logic              sync_err;
  logic              state_dbg;

  seven_seg_reader #(.NDIG(NDIG)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_in     (seg_in),
    .seg_sof    (seg_sof),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .value      (value),
    .dp         (dp),
    .blank_mask (blank_mask),
    .err_mask   (err_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sync_err   (sync_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int         checks = 0;
  int         errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0] part[$];
  logic       exp_sync;

  // Segment pattern (a..g, active-low) for each hex value 0..F.
  logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [W-1:0] model_frame();
    logic [4*NDIG-1:0] v;
    logic [NDIG-1:0]   d, bl, er;
    v = '0; d = '0; bl = '0; er = '0;
    for (int i = 0; i < NDIG; i++) begin
      int         k;
      logic [7:0] b;
      logic       found;
      k = NDIG - 1 - i;
      b = part[i];
      found = 1'b0;
      for (int j = 0; j < 16; j++) begin
        if (pat_tab[j] == b[6:0]) begin
          v[4*k +: 4] = j[3:0];
          found = 1'b1;
        end
      end
      d[k]  = ~b[7];
      bl[k] = (b[6:0] == 7'h7F);
      er[k] = !found && !bl[k];
    end
    return {v, d, bl, er};
  endfunction

  task automatic model_xfer(input logic [7:0] b, input logic sof);
    exp_sync = 1'b0;
    if (sof) begin
      part.delete();
      part.push_back(b);
    end else if (part.size() == 0) begin
      exp_sync = 1'b1;
    end else begin
      part.push_back(b);
    end
    if (part.size() == NDIG) begin
      exp_q.push_back(model_frame());
      part.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic sof);
    int n;
    seg_in    = b;
    seg_sof   = sof;
    seg_valid = 1'b1;
    n = 0;
    while (!seg_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!seg_ready) begin
      check("seg_ready_timeout", 64'd0, 64'd1);
      seg_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_xfer(b, sof);
    #1;
    seg_valid = 1'b0;
    check("sync_err", sync_err, exp_sync);
    check("out_valid_after_byte", out_valid, exp_q.size() != 0);
  endtask

  task automatic send_frame(input logic [8*NDIG-1:0] bytes);
    for (int i = NDIG - 1; i >= 0; i--) begin
      send(bytes[8*i +: 8], i == NDIG - 1);
    end
  endtask

  task automatic take_frame(input int hold);
    int n;
    logic [W-1:0] expv;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 64'd0, 64'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 64'd1, 64'd0);
      return;
    end
    expv = exp_q.pop_front();
    check("frame", {value, dp, blank_mask, err_mask}, expv);
    check("ready_low_while_valid", seg_ready, 1'b0);
    repeat (hold) begin
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_frame", {value, dp, blank_mask, err_mask}, expv);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_clear", out_valid, 1'b0);
    check("ready_after_take", seg_ready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    part.delete();
    exp_q.delete();
    check("rst_value", value, 0);
    check("rst_masks", {dp, blank_mask, err_mask}, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sync_err", sync_err, 1'b0);
    check("rst_state", state_dbg, 1'b0);
    check("rst_seg_ready", seg_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b;
    logic       sof;
    rst       = 1'b1;
    seg_in    = 8'h00;
    seg_sof   = 1'b0;
    seg_valid = 1'b0;
    out_ready = 1'b0;
    exp_sync  = 1'b0;
    idle(2);
    do_reset();

    // Back-to-back frame with the consumer always ready.
    out_ready = 1'b1;
    send_frame({8'hF9, 8'hA4, 8'hA4, 8'h92, 8'h90, 8'h90});
    take_frame(0);
    check("valid_one_cycle", out_valid, 1'b0);

    // dp, blank and E/b/F glyphs.
    send_frame({8'hC0, 8'h40, 8'hFF, 8'h8E, 8'h86, 8'h83});
    take_frame(1);

    // Unlisted pattern (0x55).
    send_frame({8'h99, 8'h55, 8'hB0, 8'hB0, 8'hB0, 8'hB0});
    take_frame(0);

    // Partial frame discarded by a new sof.
    send(8'hA4, 1'b1);
    send(8'hA4, 1'b0);
    send_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
    take_frame(0);

    // Byte without sof in IDLE: single sync_err pulse, no frame.
    send(8'h92, 1'b0);
    idle(1);
    check("sync_err_one_pulse", sync_err, 1'b0);
    check("no_frame_after_drop", out_valid, 1'b0);

    // Consumer stalls: outputs must hold and seg_ready stay low.
    send_frame({8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
    take_frame(3);

    // Reset in the middle of a frame, then a clean frame.
    send(8'hF9, 1'b1);
    send(8'hA4, 1'b0);
    send(8'hB0, 1'b0);
    do_reset();
    send_frame({8'hC0, 8'h79, 8'hA4, 8'hB0, 8'h99, 8'h92});
    take_frame(0);

    // Reset while a finished frame is pending, with out_ready also high.
    send_frame({8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});
    out_ready = 1'b1;
    do_reset();
    out_ready = 1'b0;

    // Randomized traffic: gaps, glyphs with random dp, stray patterns,
    // mid-frame restarts, dropped bytes and random consumer stalls.
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      if (part.size() == 0) begin
        sof = ($urandom_range(0, 9) != 0);
      end else begin
        sof = ($urandom_range(0, 11) == 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        b = 8'($urandom);
      end else begin
        b[6:0] = pat_tab[$urandom_range(0, 15)];
        b[7]   = 1'($urandom_range(0, 1));
      end
      send(b, sof);
      if (exp_q.size() != 0) begin
        take_frame($urandom_range(0, 2));
      end
    end
    idle(2);
    check("no_leftover_frames", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
